// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter.
// Requester count, owner width, FSM encodings and default timing.
package seg_display_defs;

    localparam int N_REQ   = 4;
    localparam int OWNER_W = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    localparam logic [15:0] DEF_DWELL      = 16'd50000;
    localparam logic [15:0] DEF_IDLE_VALUE = 16'h0000;

    typedef logic [OWNER_W-1:0] owner_t;

    function automatic logic [N_REQ-1:0] onehot(input owner_t i);
        return {{(N_REQ-1){1'b0}}, 1'b1} << i;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick4.sv
// Round-robin search over four requests starting after index start.
// The start index itself is tried last unless exclude_start is set.
module rr_pick4
    import seg_display_defs::*;
(
    input  logic [N_REQ-1:0] req,
    input  owner_t           start,
    input  logic             exclude_start,
    output logic             found,
    output owner_t           winner
);

    owner_t idx;

    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = start;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = start + owner_t'(k);
            if (!found && req[idx] && !(k == N_REQ && exclude_start)) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Grants the shared 7-segment display to one of four requesters,
// round-robin with a minimum dwell per owner, and registers its value.
module seg_display_arbiter
    import seg_display_defs::*;
#(
    parameter logic [15:0] DWELL      = DEF_DWELL,
    parameter logic [15:0] IDLE_VALUE = DEF_IDLE_VALUE
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    hold,
    input  logic [16*N_REQ-1:0] data,
    output logic [N_REQ-1:0]    grant,
    output owner_t              owner,
    output logic                valid,
    output logic [15:0]         num
);

    logic [0:0]  state;
    logic [15:0] dwell_cnt;
    logic        show;
    logic        found;
    owner_t      winner;
    logic        take;
    logic        go_idle;
    logic [15:0] win_data;
    logic [15:0] own_data;

    assign show     = (state == ST_SHOW);
    assign win_data = data[{winner, 4'b0000} +: 16];
    assign own_data = data[{owner, 4'b0000} +: 16];

    // In SHOW the owner is either released (req low) or must be
    // skipped for pre-emption, so the search always excludes it.
    rr_pick4 u_pick (
        .req           (req),
        .start         (owner),
        .exclude_start (show),
        .found         (found),
        .winner        (winner)
    );

    always_comb begin
        take    = 1'b0;
        go_idle = 1'b0;
        if (!show) begin
            take = found;
        end else if (!req[owner]) begin
            take    = found;
            go_idle = !found;
        end else if (dwell_cnt == 16'd0 && !hold[owner]) begin
            take = found;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            owner     <= owner_t'(N_REQ - 1);
            valid     <= 1'b0;
            num       <= IDLE_VALUE;
            dwell_cnt <= 16'd0;
        end else if (take) begin
            state     <= ST_SHOW;
            owner     <= winner;
            grant     <= onehot(winner);
            valid     <= 1'b1;
            num       <= win_data;
            dwell_cnt <= DWELL - 16'd1;
        end else if (go_idle) begin
            state <= ST_IDLE;
            grant <= '0;
            valid <= 1'b0;
            num   <= IDLE_VALUE;
        end else if (show) begin
            num <= own_data;
            if (dwell_cnt != 16'd0) begin
                dwell_cnt <= dwell_cnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with DWELL=4.
// Directed table, corner sequences, and random traffic against a model.
module tb_seg_display_arbiter;

    localparam int DW = 4;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  hold;
    logic [63:0] data;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        valid;
    logic [15:0] num;

    int checks;
    int errors;

    seg_display_arbiter #(
        .DWELL      (16'd4),
        .IDLE_VALUE (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .hold  (hold),
        .data  (data),
        .grant (grant),
        .owner (owner),
        .valid (valid),
        .num   (num)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  hold;
        logic [3:0]  grant;
        logic [1:0]  owner;
        logic        valid;
        logic [15:0] num;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who is showing and for how many cycles so far.
    bit          m_busy;
    int          m_owner;
    int          m_held;
    logic [15:0] m_num;

    function automatic logic [15:0] dval(input int i);
        logic [63:0] d;
        d = data;
        return d[16*i +: 16];
    endfunction

    function automatic int pick(input logic [3:0] r, input int from, input bit incl_self);
        for (int k = 1; k <= 4; k++) begin
            int i;
            i = (from + k) % 4;
            if (k == 4 && !incl_self) return -1;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_owner = 3;
        m_held  = 0;
        m_num   = 16'h0000;
    endfunction

    function automatic void model_take(input int w);
        m_busy  = 1'b1;
        m_owner = w;
        m_held  = 1;
        m_num   = dval(w);
    endfunction

    function automatic void model_edge();
        int w;
        if (!m_busy) begin
            w = pick(req, m_owner, 1'b1);
            if (w >= 0) model_take(w);
        end else if (!req[m_owner]) begin
            w = pick(req, m_owner, 1'b0);
            if (w >= 0) model_take(w);
            else begin
                m_busy = 1'b0;
                m_num  = 16'h0000;
            end
        end else begin
            w = pick(req, m_owner, 1'b0);
            if (m_held >= DW && !hold[m_owner] && w >= 0) model_take(w);
            else begin
                m_num  = dval(m_owner);
                m_held = m_held + 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 4'b0000;
        hold  = 4'b0000;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    function automatic void add(input logic [3:0] r, input logic [3:0] h,
                                input logic [3:0] g, input logic [1:0] o,
                                input logic v, input logic [15:0] n);
        vec_t e;
        e.req = r; e.hold = h; e.grant = g;
        e.owner = o; e.valid = v; e.num = n;
        tbl.push_back(e);
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        req    = 4'b1111;
        hold   = 4'b0000;
        data   = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        model_reset();

        // Reset holds outputs off even with every request set.
        repeat (2) @(negedge clock);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_num", 32'(num), 32'h0);
        chk("rst_owner", 32'(owner), 32'h3);
        req   = 4'b0100;
        reset = 1'b1;
        step();
        chk("first_grant", 32'(grant), 32'h4);
        chk("first_owner", 32'(owner), 32'h2);
        chk("first_num", 32'(num), 32'h3333);

        // Directed table: round-robin, dwell, hold, release, idle.
        for (int i = 1; i <= 4; i++) add(4'b1011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1111);
        for (int i = 1; i <= 4; i++) add(4'b1011, 4'b0000, 4'b0010, 2'd1, 1'b1, 16'h2222);
        for (int i = 1; i <= 4; i++) add(4'b1011, 4'b0000, 4'b1000, 2'd3, 1'b1, 16'h4444);
        for (int i = 1; i <= 4; i++) add(4'b1011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1111);
        for (int i = 1; i <= 8; i++) add(4'b0011, 4'b0010, 4'b0010, 2'd1, 1'b1, 16'h2222);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 16'h1111);
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'h3333);
        add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 16'h3333);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h0000);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h0000);
        add(4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1, 16'h4444);

        do_reset();
        foreach (tbl[i]) begin
            req  = tbl[i].req;
            hold = tbl[i].hold;
            step();
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].grant));
            chk($sformatf("tbl%0d_owner", i), 32'(owner), 32'(tbl[i].owner));
            chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_num", i), 32'(num), 32'(tbl[i].num));
        end

        // Sole owner tracks live data one cycle late and never loses grant.
        do_reset();
        data[63:48] = 16'hABCD;
        req = 4'b1000;
        step();
        chk("live_grant", 32'(grant), 32'h8);
        chk("live_num0", 32'(num), 32'hABCD);
        data[63:48] = 16'h1234;
        #1;
        chk("live_no_comb", 32'(num), 32'hABCD);
        step();
        chk("live_num1", 32'(num), 32'h1234);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("sole_grant", 32'(grant), 32'h8);
        end

        // Async reset between edges, then lowest requester wins.
        #3;
        reset = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'h0);
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_num", 32'(num), 32'h0);
        req = 4'b0110;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
        step();
        chk("after_async_grant", 32'(grant), 32'h2);
        chk("after_async_num", 32'(num), 32'h2222);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) hold = 4'($urandom_range(0, 15));
            data = {$urandom, $urandom};
            step();
            chk("rnd_grant", 32'(grant), m_busy ? 32'(1 << m_owner) : 32'h0);
            chk("rnd_owner", 32'(owner), 32'(m_owner));
            chk("rnd_valid", 32'(valid), 32'(m_busy));
            chk("rnd_num", 32'(num), 32'(m_num));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
Shares the single 4-digit 7-segment display between four requesters, such as the register view, PC view and debug sources. It grants one requester at a time, with round-robin order and a minimum dwell time per owner. It drives the registered 16-bit value that feeds the display decoder's num input.

Parameters:
DWELL, 16'd50000, minimum clock cycles an owner keeps the display before it can be pre-empted (legal range 1..65535)
IDLE_VALUE, 16'h0000, value driven on num when no owner

Ports:
clock  in  1  single system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req  in  4  per-requester display request, level-sensitive
hold  in  4  per-requester "keep display" flag; only meaningful for the current owner
data  in  64  requester values, data[16*i+15:16*i] belongs to requester i
grant  out  4  one-hot current owner, all-zero when idle
owner  out  2  index of current owner, last owner while idle
valid  out  1  1 when a requester owns the display
num  out  16  registered display value, to decoder num

Behaviour:
- Reset (reset==0, async): state=IDLE, grant=4'b0000, owner=2'd3 so that the first search starts at 0, valid=0, num=IDLE_VALUE, dwell_cnt=0.
- States: IDLE, SHOW (1-bit encoding).
- Round-robin pick:
  - Search order is owner+1, owner+2, owner+3, owner (mod 4).
  - The first index with req set wins.
  - "Other request" means any req[j] set with j!=owner.
- IDLE:
  - If req!=0 at edge t, then after edge t: state=SHOW, owner=winner, grant=onehot(winner), valid=1, num=data[winner], dwell_cnt=DWELL-1.
  - Latency from req to grant/num is 1 cycle.
  - Otherwise hold all outputs.
- SHOW, evaluated each edge in priority order:
  1. Release, when req[owner]==0:
     - If another request exists, switch to the round-robin winner, reload dwell_cnt=DWELL-1, num=data[new].
     - Otherwise go to IDLE: grant=0, valid=0, num=IDLE_VALUE, owner unchanged.
     - Release ignores dwell and hold.
  2. Pre-empt, when dwell_cnt==0, hold[owner]==0 and another request exists: switch to the round-robin winner (excluding owner), reload dwell_cnt.
  3. Otherwise stay in SHOW: num<=data[owner] every cycle so the display tracks live data with 1-cycle latency; dwell_cnt decrements and saturates at 0.
- A sole requester keeps the display indefinitely; dwell expiry with no other request causes no switch.
- hold only blocks pre-emption; it never blocks release. hold on non-owners is ignored.
- Simultaneous release and new request from the same index cannot occur because req is a level. A requester that drops and re-asserts req in consecutive cycles loses ownership for at least 1 cycle.
- grant is always one-hot or zero. valid==|grant. Outputs are purely registered, with no combinational path from inputs to outputs.
- Reset asserted mid-SHOW: outputs return to reset values immediately (async). First arbitration after deassertion starts at index 0.
- DWELL=1: pre-emption is possible on the cycle after grant.

Decomposition:
- Shared header/package seg_display_defs:
  - N_REQ=4 and OWNER_W=2
  - state encodings ST_IDLE, ST_SHOW
  - default IDLE_VALUE and DWELL constants
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], start[1:0], exclude_start flag.
  - Outputs: found, winner[1:0].
  - Used for both the release and pre-empt searches.
- Dwell counter and FSM stay in the top module.

Test Plan (DWELL=4 unless stated):
- Reset: with reset=0, drive req=4'b1111 -> grant=0, valid=0, num=16'h0000. Release reset with req=4'b0100 -> next edge grant=4'b0100, owner=2, num=data[2].
- Dwell/round-robin: req=4'b1011, data0=16'h1111, data1=16'h2222, data3=16'h4444 -> grant sequence 0001, 0010, 1000, 0001, each owner held exactly 4 cycles; num follows with values 1111, 2222, 4444.
- Hold: owner 1 with hold[1]=1 and req=4'b0011 -> grant stays 4'b0010 past 4 cycles. Deassert hold[1] -> switch to 4'b0001 on the next edge.
- Early release: owner 0 at cycle 1 of dwell drops req[0] while req[2]=1 -> next edge grant=4'b0100, dwell reloaded. With no other request -> IDLE, num=16'h0000, valid=0.
- Live tracking / sole owner: only req[3]; change data3 from 16'hABCD to 16'h1234 -> num changes exactly 1 cycle later; grant stays 4'b1000 for 100 cycles.
- Async reset mid-SHOW: pull reset low between edges -> grant, valid and num clear without a clock edge. After release, first grant goes to the lowest requesting index.
